// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC, instruction-memory address, delay-slot tagging, stall/flush.
// Optional fetch-exception detection is built when FETCH_EXC_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  input  logic        D_is_br,
  output logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8,
  output logic        D_valid,
  output logic        D_bd,
  output logic        D_exc,
  output logic [4:0]  D_exccode
);

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic        d_bd_q, d_bd_d;
  logic [31:0] target, fetch_word;
  logic        f_exc;

`ifdef FETCH_EXC_EN
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;
  logic       d_exc_q, d_exc_d;
  logic [4:0] d_exccode_q, d_exccode_d;

  // Misaligned or out-of-range fetch: feed a nop and tag it (AdEL) so D_pc becomes EPC.
  assign target = npc_target;
  assign f_exc  = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_BASE) ||
                  ({1'b0, f_pc_q} >= IM_END);
  assign D_exc     = d_exc_q;
  assign D_exccode = d_exccode_q;
`else
  logic unused_tgt_lo;
  assign unused_tgt_lo = ^npc_target[1:0];
  assign target    = {npc_target[31:2], 2'b00};
  assign f_exc     = 1'b0;
  assign D_exc     = 1'b0;
  assign D_exccode = 5'd0;
`endif

  assign fetch_word = f_exc ? 32'h0 : i_data;

  always_comb begin
    f_pc_d    = f_pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    d_bd_d    = d_bd_q;
`ifdef FETCH_EXC_EN
    d_exc_d     = d_exc_q;
    d_exccode_d = d_exccode_q;
`endif
    if (flush) begin
      f_pc_d    = target;
      d_instr_d = 32'h0;
      d_pc_d    = f_pc_q;
      d_valid_d = 1'b0;
      d_bd_d    = 1'b0;
`ifdef FETCH_EXC_EN
      d_exc_d     = 1'b0;
      d_exccode_d = 5'd0;
`endif
    end else if (!stall) begin
      // The word in F always advances, so a redirect keeps its delay slot.
      f_pc_d    = npc_sel ? target : f_pc_q + 32'd4;
      d_instr_d = fetch_word;
      d_pc_d    = f_pc_q;
      d_valid_d = 1'b1;
      d_bd_d    = D_is_br;
`ifdef FETCH_EXC_EN
      d_exc_d     = f_exc;
      d_exccode_d = f_exc ? 5'd4 : 5'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q    <= RESET_PC;
      d_instr_q <= 32'h0;
      d_pc_q    <= 32'h0;
      d_valid_q <= 1'b0;
      d_bd_q    <= 1'b0;
`ifdef FETCH_EXC_EN
      d_exc_q     <= 1'b0;
      d_exccode_q <= 5'd0;
`endif
    end else begin
      f_pc_q    <= f_pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
      d_bd_q    <= d_bd_d;
`ifdef FETCH_EXC_EN
      d_exc_q     <= d_exc_d;
      d_exccode_q <= d_exccode_d;
`endif
    end
  end

  assign i_addr  = f_pc_q;
  assign D_instr = d_instr_q;
  assign D_pc    = d_pc_q;
  assign D_pc8   = d_pc_q + 32'd8;
  assign D_valid = d_valid_q;
  assign D_bd    = d_bd_q;

endmodule
